// File: rtl/uart_pkg.sv
// UART register map, STATUS bit positions and the bridge FSM encoding shared by the
// uart_fifo_bridge block and its sub-modules.
package uart_pkg;

  localparam logic [31:0] UART_CTRL   = 32'h00;
  localparam logic [31:0] UART_STATUS = 32'h04;
  localparam logic [31:0] UART_BAUD   = 32'h08;
  localparam logic [31:0] UART_TXDATA = 32'h0C;
  localparam logic [31:0] UART_RXDATA = 32'h10;

  localparam int unsigned STATUS_TX_BUSY = 0;
  localparam int unsigned STATUS_RX_OVER = 1;

  localparam logic [31:0] CTRL_TX_EN   = 32'h1;
  localparam logic [31:0] CTRL_TXRX_EN = 32'h3;

  typedef enum logic [2:0] {
    S_INIT_BAUD,
    S_INIT_CTRL,
    S_IDLE,
    S_TX_WRITE,
    S_RX_READ,
    S_RX_CLR
  } bridge_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push and pop on a full FIFO in the same cycle are
// both accepted. Head reads as zero while empty so no stale data leaks out after reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW + 1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Byte-stream front end that configures the uart and then polls STATUS to move bytes between
// two FIFOs and the UART register port. RX path is built only with UART_FIFO_BRIDGE_RX_EN.
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] BAUD_DIV = 32'h1B8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_ready_o,
  output logic        rx_valid_o,
  output logic [7:0]  rx_data_o,
  input  logic        rx_ready_i,
  output logic        rx_overflow_o,
  output logic        init_done_o,
  output logic        u_we_o,
  output logic [31:0] u_addr_o,
  output logic [31:0] u_data_o,
  input  logic [31:0] u_data_i
);

  bridge_state_e state_q, state_d;
  logic          init_done_q, init_done_d;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]    tx_head;
  logic          rx_req;
  logic          bus_we;
  logic [31:0]   bus_addr, bus_wdata;

  assign tx_ready_o = !tx_full;
  assign tx_push    = tx_valid_i && !tx_full;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_push),
    .wdata(tx_data_i),
    .pop  (tx_pop),
    .full (tx_full),
    .empty(tx_empty),
    .head (tx_head)
  );

`ifdef UART_FIFO_BRIDGE_RX_EN
  localparam logic [31:0] CtrlInit = CTRL_TXRX_EN;

  logic       rx_full, rx_empty, rx_push, rx_pop;
  logic       rx_overflow_q, rx_overflow_d;
  logic [7:0] rx_head;
  logic       unused_data;

  assign rx_req      = u_data_i[STATUS_RX_OVER];
  assign rx_pop      = rx_ready_i && !rx_empty;
  // A same-cycle consumer pop frees the slot, so the byte is only lost if no pop happens.
  assign rx_push       = (state_q == S_RX_READ) && (!rx_full || rx_pop);
  assign rx_overflow_d = rx_overflow_q || ((state_q == S_RX_READ) && rx_full && !rx_pop);
  assign unused_data   = ^u_data_i[31:8];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_push),
    .wdata(u_data_i[7:0]),
    .pop  (rx_ready_i),
    .full (rx_full),
    .empty(rx_empty),
    .head (rx_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) rx_overflow_q <= 1'b0;
    else      rx_overflow_q <= rx_overflow_d;
  end

  assign rx_valid_o    = !rx_empty;
  assign rx_data_o     = rx_head;
  assign rx_overflow_o = rx_overflow_q;
`else
  localparam logic [31:0] CtrlInit = CTRL_TX_EN;

  logic unused_rx;

  assign rx_req        = 1'b0;
  assign unused_rx     = rx_ready_i ^ (^u_data_i[31:1]);
  assign rx_valid_o    = 1'b0;
  assign rx_data_o     = 8'h00;
  assign rx_overflow_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    bus_we      = 1'b0;
    bus_addr    = UART_STATUS;
    bus_wdata   = '0;
    tx_pop      = 1'b0;
    unique case (state_q)
      S_INIT_BAUD: begin
        bus_we    = 1'b1;
        bus_addr  = UART_BAUD;
        bus_wdata = BAUD_DIV;
        state_d   = S_INIT_CTRL;
      end
      S_INIT_CTRL: begin
        bus_we      = 1'b1;
        bus_addr    = UART_CTRL;
        bus_wdata   = CtrlInit;
        state_d     = S_IDLE;
        init_done_d = 1'b1;
      end
      S_IDLE: begin
        if (rx_req) begin
          state_d = S_RX_READ;
        end else if (!u_data_i[STATUS_TX_BUSY] && !tx_empty) begin
          state_d = S_TX_WRITE;
        end
      end
      S_TX_WRITE: begin
        bus_we    = 1'b1;
        bus_addr  = UART_TXDATA;
        bus_wdata = {24'h0, tx_head};
        tx_pop    = 1'b1;
        state_d   = S_IDLE;
      end
`ifdef UART_FIFO_BRIDGE_RX_EN
      S_RX_READ: begin
        bus_addr = UART_RXDATA;
        state_d  = S_RX_CLR;
      end
      S_RX_CLR: begin
        bus_we   = 1'b1;
        bus_addr = UART_STATUS;
        state_d  = S_IDLE;
      end
`endif
      default: state_d = S_INIT_BAUD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_INIT_BAUD;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
    end
  end

  // Bus is held quiet while reset is applied so the UART never sees the init write early.
  assign u_we_o      = rst && bus_we;
  assign u_addr_o    = rst ? bus_addr : '0;
  assign u_data_o    = rst ? bus_wdata : '0;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a small UART register model and TX/RX scoreboards;
// RX scenarios are built when UART_FIFO_BRIDGE_RX_EN is defined.
module tb_uart_fifo_bridge;
  import uart_pkg::*;

`ifdef UART_FIFO_BRIDGE_RX_EN
  localparam logic [31:0] CTRL_EXP = 32'h3;
`else
  localparam logic [31:0] CTRL_EXP = 32'h1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, rx_overflow, init_done, u_we;
  logic [7:0]  tx_data, rx_data;
  logic [31:0] u_addr, u_wdata, u_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // UART model state
  int         busy_cnt = 0;
  int         busy_len = 0;
  logic       hold_busy = 1'b0;
  int         rx_req_cnt = 0;
  int         rx_clr_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       busy, rx_over;

  // Scoreboards and monitor results
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         wr_count = 0;
  int         last_wr_cyc = 0;
  int         prev_gap = 0;
  int         exp_writes = 0;
  int         push_cyc, rx_cyc;

  always #5 clk = ~clk;

  uart_fifo_bridge #(
    .DEPTH(8),
    .BAUD_DIV(32'h1B8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_valid_i   (tx_valid),
    .tx_data_i    (tx_data),
    .tx_ready_o   (tx_ready),
    .rx_valid_o   (rx_valid),
    .rx_data_o    (rx_data),
    .rx_ready_i   (rx_ready),
    .rx_overflow_o(rx_overflow),
    .init_done_o  (init_done),
    .u_we_o       (u_we),
    .u_addr_o     (u_addr),
    .u_data_o     (u_wdata),
    .u_data_i     (u_rdata)
  );

  assign busy    = (busy_cnt != 0) || hold_busy;
  assign rx_over = (rx_req_cnt != rx_clr_cnt);

  always_comb begin
    u_rdata = '0;
    if (u_addr == UART_STATUS)      u_rdata = {30'd0, rx_over, busy};
    else if (u_addr == UART_RXDATA) u_rdata = {24'd0, rx_byte};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      busy_cnt   <= 0;
      rx_clr_cnt <= rx_req_cnt;
    end else if (u_we && u_addr == UART_TXDATA) begin
      busy_cnt <= busy_len;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (u_we && u_addr == UART_STATUS && rx_over) rx_clr_cnt <= rx_clr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // TXDATA monitor: order, data, and never while the model reports busy.
  always @(negedge clk) begin
    if (rst && u_we && u_addr == UART_TXDATA) begin
      check("tx_busy_at_write", 32'(busy), 32'd0);
      check("tx_expected_pending", 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) check("tx_data", u_wdata, {24'd0, tx_q.pop_front()});
      wr_count    <= wr_count + 1;
      prev_gap    <= cyc - last_wr_cyc;
      last_wr_cyc <= cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wr_count < n && k < budget) begin
      step(1);
      k++;
    end
    check("tx_write_count", wr_count, n);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    #1;
    check("init_baud_we", 32'(u_we), 32'd1);
    check("init_baud_addr", u_addr, UART_BAUD);
    check("init_baud_data", u_wdata, 32'h1B8);
    check("init_done_c1", 32'(init_done), 32'd0);
    check("tx_ready_c1", 32'(tx_ready), 32'd1);
    step(1);
    check("init_ctrl_we", 32'(u_we), 32'd1);
    check("init_ctrl_addr", u_addr, UART_CTRL);
    check("init_ctrl_data", u_wdata, CTRL_EXP);
    check("init_done_c2", 32'(init_done), 32'd0);
    step(1);
    check("init_done_c3", 32'(init_done), 32'd1);
    check("idle_we", 32'(u_we), 32'd0);
    check("idle_addr", u_addr, UART_STATUS);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    rx_ready = 1'b0;
    step(3);
    check("rst_we", 32'(u_we), 32'd0);
    check("rst_addr", u_addr, 32'd0);
    check("rst_data", u_wdata, 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_overflow", 32'(rx_overflow), 32'd0);
    release_reset();

    // Single byte, UART idle: write two cycles after the push cycle
    tx_valid = 1'b1;
    tx_data = 8'h55;
    tx_q.push_back(8'h55);
    exp_writes++;
    push_cyc = cyc;
    check("tx_ready_empty", 32'(tx_ready), 32'd1);
    step(1);
    tx_valid = 1'b0;
    wait_writes(exp_writes, 20);
    check("tx_latency", last_wr_cyc - push_cyc, 32'd2);

    // Fill while busy, then drain one byte per 100-cycle busy window
    hold_busy = 1'b1;
    busy_len = 100;
    step(1);
    for (int i = 1; i <= 8; i++) begin
      tx_valid = 1'b1;
      tx_data = 8'(i);
      tx_q.push_back(8'(i));
      check("tx_ready_fill", 32'(tx_ready), 32'd1);
      step(1);
    end
    check("tx_ready_full", 32'(tx_ready), 32'd0);
    tx_data = 8'hEE;
    step(1);
    tx_valid = 1'b0;
    check("tx_ready_still_full", 32'(tx_ready), 32'd0);
    hold_busy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wait_writes(exp_writes + i, 150);
      if (i >= 2) check("tx_gap", prev_gap, 32'd102);
    end
    exp_writes += 8;
    step(105);
    busy_len = 0;

`ifdef UART_FIFO_BRIDGE_RX_EN
    // Single RX byte: READ, CLR, data visible two cycles after bit1 is seen
    rx_byte = 8'hA5;
    rx_req_cnt++;
    rx_q.push_back(8'hA5);
    check("rx_idle_addr", u_addr, UART_STATUS);
    step(1);
    check("rx_read_addr", u_addr, UART_RXDATA);
    check("rx_read_we", 32'(u_we), 32'd0);
    check("rx_valid_early", 32'(rx_valid), 32'd0);
    step(1);
    check("rx_clr_we", 32'(u_we), 32'd1);
    check("rx_clr_addr", u_addr, UART_STATUS);
    check("rx_clr_data", u_wdata, 32'd0);
    check("rx_valid_lat", 32'(rx_valid), 32'd1);
    check("rx_data_lat", 32'(rx_data), {24'd0, rx_q[0]});
    step(1);
    rx_ready = 1'b1;
    check("rx_pop_data", 32'(rx_data), {24'd0, rx_q.pop_front()});
    step(1);
    rx_ready = 1'b0;
    check("rx_empty_after_pop", 32'(rx_valid), 32'd0);

    // Nine bytes with no consumer: eight kept in order, ninth dropped
    for (int k = 0; k < 9; k++) begin
      if (k == 8) check("rx_overflow_pre", 32'(rx_overflow), 32'd0);
      rx_byte = 8'(8'h10 + k);
      rx_req_cnt++;
      if (k < 8) rx_q.push_back(8'(8'h10 + k));
      step(3);
    end
    check("rx_overflow_set", 32'(rx_overflow), 32'd1);
    rx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("rx_valid_drain", 32'(rx_valid), 32'd1);
      check("rx_fifo_data", 32'(rx_data), {24'd0, rx_q.pop_front()});
      step(1);
    end
    rx_ready = 1'b0;
    check("rx_drained", 32'(rx_valid), 32'd0);
    check("rx_overflow_sticky", 32'(rx_overflow), 32'd1);

    // RX request and pending TX in the same IDLE cycle: RX wins
    hold_busy = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h77;
    tx_q.push_back(8'h77);
    exp_writes++;
    step(1);
    tx_valid = 1'b0;
    step(1);
    rx_byte = 8'h5A;
    rx_req_cnt++;
    hold_busy = 1'b0;
    rx_q.push_back(8'h5A);
    rx_cyc = cyc;
    step(1);
    check("prio_rx_read", u_addr, UART_RXDATA);
    step(1);
    check("prio_rx_clr", u_addr, UART_STATUS);
    check("prio_rx_clr_we", 32'(u_we), 32'd1);
    wait_writes(exp_writes, 10);
    check("prio_tx_after_rx", last_wr_cyc - rx_cyc, 32'd4);
    rx_ready = 1'b1;
    check("prio_rx_data", 32'(rx_data), {24'd0, rx_q.pop_front()});
    step(1);
    rx_ready = 1'b0;
`else
    // Without the RX path STATUS bit1 is ignored and RX outputs stay zero
    rx_req_cnt++;
    step(1);
    check("norx_idle_addr", u_addr, UART_STATUS);
    check("norx_idle_we", 32'(u_we), 32'd0);
    step(2);
    check("norx_still_idle", u_addr, UART_STATUS);
    check("norx_rx_valid", 32'(rx_valid), 32'd0);
    check("norx_rx_data", 32'(rx_data), 32'd0);
    check("norx_overflow", 32'(rx_overflow), 32'd0);
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    tx_q.push_back(8'h3C);
    exp_writes++;
    push_cyc = cyc;
    step(1);
    tx_valid = 1'b0;
    wait_writes(exp_writes, 20);
    check("norx_tx_latency", last_wr_cyc - push_cyc, 32'd2);
`endif

    // Reset mid-operation: queued TX byte discarded, init reruns
    hold_busy = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h99;
    step(1);
    tx_valid = 1'b0;
`ifdef UART_FIFO_BRIDGE_RX_EN
    rx_byte = 8'hC3;
    rx_req_cnt++;
    step(1);
    check("midrst_in_read", u_addr, UART_RXDATA);
`endif
    rst = 1'b0;
    #1;
    check("midrst_we", 32'(u_we), 32'd0);
    check("midrst_addr", u_addr, 32'd0);
    check("midrst_data", u_wdata, 32'd0);
    step(1);
    hold_busy = 1'b0;
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_overflow", 32'(rx_overflow), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    release_reset();
    step(5);
    check("midrst_tx_discarded", wr_count, exp_writes);
    check("midrst_rx_empty", 32'(rx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
